and3_resp_checker: RTL and testbench

Synchronous response checker for the 3-input AND gate under test: the receiving end of the exhaustive stimulus sequence. It samples each applied input vector with the gate's output, compares against the expected AND, and counts mismatches. It tracks which of the 2^N_IN vectors have been seen, records the first failing vector, and reports pass/fail once coverage is complete or a timeout expires. The checker sits beside the gate in self-checking simulation and on-board self-test builds, downstream of the stimulus driver.

---
 rtl/and3_resp_checker_pkg.sv | 25 ++
 rtl/and3_resp_checker_if.sv | 26 ++
 rtl/and3_resp_checker_sat_counter.sv | 35 +++
 rtl/and3_resp_checker.sv | 120 ++++++++++++
 tb/tb_and3_resp_checker.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/and3_resp_checker_pkg.sv
// Shared types and constants for the 3-input AND response checker.
// Imported by the checker top and its interface users.
package and3_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int N_IN_DEF = 3;
  localparam int NVEC     = 2**N_IN_DEF;
  localparam int COV_MAX  = 256;

  // Mask with the low 2**n bits set; callers slice to their width.
  function automatic logic [COV_MAX-1:0] cov_ones(input int n);
    logic [COV_MAX-1:0] m;
    m = '0;
    for (int k = 0; k < COV_MAX; k++) begin
      if (k < (1 << n)) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/and3_resp_checker_if.sv
// Stimulus-side bundle seen by the response checker.
// The stimulus driver is the master, the checker the slave.
interface and3_resp_checker_if #(
  parameter int N_IN = 3
);

  logic            start;
  logic            vec_valid;
  logic [N_IN-1:0] vec_in;
  logic            dut_out;

  modport master (
    output start,
    output vec_valid,
    output vec_in,
    output dut_out
  );

  modport slave (
    input start,
    input vec_valid,
    input vec_in,
    input dut_out
  );

endinterface

// File: rtl/and3_resp_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/and3_resp_checker.sv
// Response checker for the AND gate under test: scores each sampled
// vector, tracks coverage and finishes on full coverage or timeout.
module and3_resp_checker
  import and3_chk_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int ERR_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  and3_resp_checker_if.slave   stim,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timed_out,
  output logic [ERR_W-1:0]     err_cnt,
  output logic                 first_err_valid,
  output logic [N_IN-1:0]      first_err_vec,
  output logic [(2**N_IN)-1:0] coverage
);

  localparam int NV = 2**N_IN;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [COV_MAX-1:0] COV_ALL_W = cov_ones(N_IN);
  localparam logic [NV-1:0]      COV_ALL   = COV_ALL_W[NV-1:0];
  localparam logic [TW-1:0]      TMO_LAST  = TW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [NV-1:0]   cov_q, cov_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            tout_q, tout_d;
  logic            fev_q, fev_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            clr;
  logic            mis;
  logic [ERR_W-1:0] err_q;

  always_comb begin
    state_d = state_q;
    cov_d   = cov_q;
    tmo_d   = tmo_q;
    tout_d  = tout_q;
    fev_d   = fev_q;
    fvec_d  = fvec_q;
    clr     = 1'b0;
    mis     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (stim.start) begin
          state_d = RUN;
          clr     = 1'b1;
          cov_d   = '0;
          tmo_d   = '0;
          tout_d  = 1'b0;
          fev_d   = 1'b0;
          fvec_d  = '0;
        end
      end
      RUN: begin
        mis = stim.vec_valid &&
              (stim.dut_out != (&stim.vec_in));
        if (stim.vec_valid) cov_d[stim.vec_in] = 1'b1;
        if (mis && !fev_q) begin
          fev_d  = 1'b1;
          fvec_d = stim.vec_in;
        end
        // Full coverage takes precedence over a simultaneous timeout.
        if (cov_d == COV_ALL) begin
          state_d = DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = DONE;
          tout_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cov_q   <= '0;
      tmo_q   <= '0;
      tout_q  <= 1'b0;
      fev_q   <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      cov_q   <= cov_d;
      tmo_q   <= tmo_d;
      tout_q  <= tout_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (mis),
    .count (err_q)
  );

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = done && (err_q == '0) && !tout_q;
  assign timed_out       = tout_q;
  assign err_cnt         = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;
  assign coverage        = cov_q;

endmodule

// File: tb/tb_and3_resp_checker.sv
// Self-checking bench for and3_resp_checker against a
// behavioural model of the checking rules.
module tb_and3_resp_checker;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy, done, pass, timed_out;
  logic [7:0] err_cnt;
  logic       first_err_valid;
  logic [2:0] first_err_vec;
  logic [7:0] coverage;

  int checks = 0;
  int failures = 0;

  bit       m_run, m_fin, m_to;
  int       m_err, m_first, m_cyc;
  bit [7:0] m_seen;

  always #5 clk = ~clk;

  and3_resp_checker_if #(.N_IN(3)) stim ();

  and3_resp_checker #(
    .N_IN(3),
    .ERR_W(8),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stim            (stim),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .timed_out       (timed_out),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec),
    .coverage        (coverage)
  );

  function automatic void model(input bit r, input bit s,
                                input bit v, input bit [2:0] vec,
                                input bit o);
    if (!r) begin
      m_run = 0; m_fin = 0; m_to = 0;
      m_err = 0; m_first = -1; m_cyc = 0; m_seen = 0;
    end else if (!m_run) begin
      if (s) begin
        m_run = 1; m_fin = 0; m_to = 0;
        m_err = 0; m_first = -1; m_cyc = 0; m_seen = 0;
      end
    end else begin
      m_cyc++;
      if (v) begin
        if (o != (vec == 3'b111)) begin
          if (m_err < 255) m_err++;
          if (m_first < 0) m_first = int'(vec);
        end
        m_seen[vec] = 1'b1;
      end
      if (m_seen == 8'hFF) begin
        m_run = 0; m_fin = 1;
      end else if (m_cyc == TIMEOUT) begin
        m_run = 0; m_fin = 1; m_to = 1;
      end
    end
  endfunction

  function automatic logic [23:0] obs();
    return {busy, done, pass, timed_out, err_cnt,
            first_err_valid, first_err_vec, coverage};
  endfunction

  function automatic logic [23:0] expv();
    logic [2:0] fv;
    fv = (m_first >= 0) ? 3'(m_first) : 3'b000;
    return {m_run, m_fin, m_fin && (m_err == 0) && !m_to, m_to,
            8'(m_err), (m_first >= 0), fv, m_seen};
  endfunction

  task automatic step(input bit r, input bit s, input bit v,
                      input bit [2:0] vec, input bit o);
    @(negedge clk);
    rst_n = r;
    stim.start = s;
    stim.vec_valid = v;
    stim.vec_in = vec;
    stim.dut_out = o;
    @(posedge clk);
    model(r, s, v, vec, o);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 3'b111, 0);
    checks++;
    if (obs() !== 24'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs(), 24'h0);
    end
    step(1, 1, 0, 0, 0);
    step(1, 0, 1, 3'b000, 1);
    step(1, 0, 1, 3'b001, 1);
    checks++;
    if (err_cnt !== 8'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_err got=%0d/%b exp=2/1",
               err_cnt, busy);
    end
    step(0, 0, 1, 3'b010, 1);
    checks++;
    if (obs() !== 24'h0) begin
      failures++;
      $display("FAIL reset_mid_run got=%h exp=%h", obs(), 24'h0);
    end
  endtask

  task automatic test_correct_gate();
    step(1, 1, 0, 0, 0);
    for (int v = 0; v < 8; v++) begin
      step(1, 0, 1, 3'(v), v == 7);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL correct_v%0d got=%h exp=%h", v, obs(), expv());
      end
    end
    checks++;
    if ({busy, done, pass, err_cnt, coverage} !== {3'b011, 8'd0, 8'hFF}) begin
      failures++;
      $display("FAIL correct_final got=%b%b%b/%0d/%h exp=011/0/ff",
               busy, done, pass, err_cnt, coverage);
    end
  endtask

  task automatic test_stuck0();
    step(1, 1, 0, 0, 0);
    for (int v = 0; v < 8; v++) begin
      step(1, 0, 1, 3'(v), 0);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL stuck0_v%0d got=%h exp=%h", v, obs(), expv());
      end
    end
    checks++;
    if ({done, pass, err_cnt, first_err_valid, first_err_vec}
        !== {2'b10, 8'd1, 1'b1, 3'b111}) begin
      failures++;
      $display("FAIL stuck0_final got=%b%b/%0d/%b/%b exp=10/1/1/111",
               done, pass, err_cnt, first_err_valid, first_err_vec);
    end
  endtask

  task automatic test_stuck1_restart();
    step(1, 1, 0, 0, 0);
    for (int v = 0; v < 8; v++) begin
      step(1, 0, 1, 3'(v), 1);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL stuck1_v%0d got=%h exp=%h", v, obs(), expv());
      end
    end
    checks++;
    if ({err_cnt, first_err_vec, pass} !== {8'd7, 3'b000, 1'b0}) begin
      failures++;
      $display("FAIL stuck1_final got=%0d/%b/%b exp=7/000/0",
               err_cnt, first_err_vec, pass);
    end
    step(1, 1, 1, 3'b011, 1);
    checks++;
    if ({busy, done, err_cnt, first_err_valid, coverage}
        !== {2'b10, 8'd0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL restart_clear got=%h exp=busy-only", obs());
    end
    for (int v = 7; v >= 0; v--) begin
      step(1, 0, 1, 3'(v), v == 7);
    end
    checks++;
    if ({done, pass, err_cnt} !== {2'b11, 8'd0}) begin
      failures++;
      $display("FAIL restart_pass got=%b%b/%0d exp=11/0",
               done, pass, err_cnt);
    end
  endtask

  task automatic test_timeout();
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) begin
      step(1, 0, 1, 3'(i % 7), 0);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL timeout_c%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    checks++;
    if ({busy, done, timed_out, pass, coverage}
        !== {4'b0110, 8'h7F}) begin
      failures++;
      $display("FAIL timeout_final got=%b%b%b%b/%h exp=0110/7f",
               busy, done, timed_out, pass, coverage);
    end
  endtask

  task automatic test_cov_at_timeout();
    bit [2:0] vec;
    bit       v, s;
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) begin
      s = 0;
      if (i < 7) begin
        v = 1; vec = 3'(i);
      end else if (i < TIMEOUT - 1) begin
        v = 1'($urandom); vec = 3'($urandom_range(0, 6));
        s = 1'($urandom);
      end else begin
        v = 1; vec = 3'b111;
      end
      step(1, s, v, vec, vec == 3'b111);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL covtmo_c%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    checks++;
    if ({done, timed_out, pass, coverage} !== {3'b101, 8'hFF}) begin
      failures++;
      $display("FAIL covtmo_final got=%b%b%b/%h exp=101/ff",
               done, timed_out, pass, coverage);
    end
  endtask

  task automatic test_random();
    bit [2:0] vec;
    bit       v, o, s;
    for (int run = 0; run < 6; run++) begin
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < TIMEOUT + 8; i++) begin
        v = ($urandom_range(0, 3) != 0);
        vec = 3'($urandom);
        o = (vec == 3'b111) ^ ($urandom_range(0, 7) == 0);
        s = ($urandom_range(0, 15) == 0);
        step(1, s, v, vec, o);
        checks++;
        if (obs() !== expv()) begin
          failures++;
          $display("FAIL rand_r%0d_c%0d got=%h exp=%h",
                   run, i, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stim.start = 1'b0;
    stim.vec_valid = 1'b0;
    stim.vec_in = '0;
    stim.dut_out = 1'b0;
    model(0, 0, 0, 0, 0);
    test_reset();
    test_correct_gate();
    test_stuck0();
    test_stuck1_restart();
    test_timeout();
    test_cov_at_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
